radix8_mul_seq_ctrl: RTL and testbench

//  Iterative unsigned DATA_WIDTH x DATA_WIDTH multiplier controller built around radix-8 digit selection.

---
 rtl/radix8_mul_pkg.sv | 14 +
 rtl/radix8_pp_select.sv | 37 +++
 rtl/radix8_mul_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_radix8_mul_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/radix8_mul_pkg.sv
// Shared types and helpers for the radix-8 sequential multiplier.
package radix8_mul_pkg;

   typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

   localparam int DIGIT_WIDTH = 3;

   typedef logic [6:0] booth_sel_t;

   function automatic int num_digits(input int width);
      return (width + DIGIT_WIDTH - 1) / DIGIT_WIDTH;
   endfunction

endpackage

// File: rtl/radix8_pp_select.sv
// Radix-8 digit decode and one-hot partial-product multiple mux.
module radix8_pp_select
   import radix8_mul_pkg::*;
#(
   parameter int MW = 11
) (
   input  logic [DIGIT_WIDTH-1:0] digit,
   input  logic [MW-1:0]          m1,
   input  logic [MW-1:0]          m2,
   input  logic [MW-1:0]          m3,
   input  logic [MW-1:0]          m4,
   input  logic [MW-1:0]          m5,
   input  logic [MW-1:0]          m6,
   input  logic [MW-1:0]          m7,
   output booth_sel_t             sel,
   output logic [MW-1:0]          pp
);

   logic [7:0] oh;

   always_comb begin
      oh  = 8'b1 << digit;
      sel = oh[7:1];
      pp  = '0;
      unique case (1'b1)
         sel[0]:  pp = m1;
         sel[1]:  pp = m2;
         sel[2]:  pp = m3;
         sel[3]:  pp = m4;
         sel[4]:  pp = m5;
         sel[5]:  pp = m6;
         sel[6]:  pp = m7;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/radix8_mul_seq_ctrl.sv
// Iterative radix-8 unsigned multiplier controller, one digit per cycle.
// Optional EARLY_TERM_EN skips iterations once remaining digits are zero.
module radix8_mul_seq_ctrl
   import radix8_mul_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   input  logic                    iValid,
   output logic                    oReady,
   input  logic [DATA_WIDTH-1:0]   iMcand,
   input  logic [DATA_WIDTH-1:0]   iMplier,
   output logic                    oValid,
   input  logic                    iReady,
   output logic [2*DATA_WIDTH-1:0] oProd,
   output logic                    oBusy,
   output booth_sel_t              oBoothSel
);

   localparam int NUM_DIGITS = num_digits(DATA_WIDTH);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int MW = DATA_WIDTH + 3;
   localparam int XW = DIGIT_WIDTH * NUM_DIGITS;
   localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NUM_DIGITS - 1);

   state_t                 state;
   state_t                 nstate;
   logic [DATA_WIDTH-1:0]  mcand;
   logic [XW-1:0]          mplier;
   logic [MW-1:0]          m1, m2, m3, m4, m5, m6, m7;
   logic [MW-1:0]          pp;
   logic [PW-1:0]          acc;
   logic [PW-1:0]          addend;
   logic [KW-1:0]          k;
   logic [DIGIT_WIDTH-1:0] digit;
   logic                   last;

   assign m1 = MW'(mcand);
   assign m2 = MW'({mcand, 1'b0});
   assign m4 = MW'({mcand, 2'b00});
   assign m6 = m3 << 1;

   assign digit = (state == ITER)
                ? mplier[DIGIT_WIDTH*k +: DIGIT_WIDTH]
                : '0;

   assign addend = PW'(pp) << (DIGIT_WIDTH * int'(k));

`ifdef EARLY_TERM_EN
   assign last = (k == KLAST) ||
                 ((mplier >> (DIGIT_WIDTH * (int'(k) + 1))) == '0);
`else
   assign last = (k == KLAST);
`endif

   radix8_pp_select #(.MW(MW)) u_sel (
      .digit (digit),
      .m1    (m1),
      .m2    (m2),
      .m3    (m3),
      .m4    (m4),
      .m5    (m5),
      .m6    (m6),
      .m7    (m7),
      .sel   (oBoothSel),
      .pp    (pp)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state <= IDLE;
      else         state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (iValid) nstate = PRE;
         PRE:     nstate = ITER;
         ITER:    if (last) nstate = DONE;
         DONE:    if (iReady) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // 3x/5x/7x are the odd multiples that need an adder; the rest are shifts
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         mcand  <= '0;
         mplier <= '0;
         m3     <= '0;
         m5     <= '0;
         m7     <= '0;
         acc    <= '0;
         k      <= '0;
      end else begin
         unique case (state)
            IDLE: if (iValid) begin
               mcand  <= iMcand;
               mplier <= XW'(iMplier);
               acc    <= '0;
               k      <= '0;
            end
            PRE: begin
               m3 <= m1 + m2;
               m5 <= m1 + m4;
               m7 <= MW'({mcand, 3'b000}) - m1;
            end
            ITER: begin
               acc <= acc + addend;
               k   <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign oReady = (state == IDLE);
   assign oBusy  = (state != IDLE);
   assign oValid = (state == DONE);
   assign oProd  = acc;

endmodule

// File: tb/tb_radix8_mul_seq_ctrl.sv
// Directed and random checks of radix8_mul_seq_ctrl against a queue model.
module tb_radix8_mul_seq_ctrl;

   logic        iClk = 1'b0;
   logic        iRst_n;
   logic        iValid;
   logic        oReady;
   logic [7:0]  iMcand;
   logic [7:0]  iMplier;
   logic        oValid;
   logic        iReady;
   logic [15:0] oProd;
   logic        oBusy;
   logic [6:0]  oBoothSel;

   int n_chk  = 0;
   int n_fail = 0;
   int n_out  = 0;
   int lat;
   logic [15:0] sb_q[$];
   logic [6:0]  sel_log[0:63];

   radix8_mul_seq_ctrl #(.DATA_WIDTH(8)) dut (
      .iClk      (iClk),
      .iRst_n    (iRst_n),
      .iValid    (iValid),
      .oReady    (oReady),
      .iMcand    (iMcand),
      .iMplier   (iMplier),
      .oValid    (oValid),
      .iReady    (iReady),
      .oProd     (oProd),
      .oBusy     (oBusy),
      .oBoothSel (oBoothSel)
   );

   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_sel(input logic [8:0] m, input int j);
      logic [8:0] s;
      logic [2:0] d;
      s = m >> (3 * j);
      d = s[2:0];
      return (d == 3'd0) ? 7'd0 : 7'(7'd1 << (d - 1));
   endfunction

   // drive one operation, wait for result, compare, optional backpressure
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input bit hold, input int bp,
                        output int latency);
      int n;
      logic [15:0] e;
      iMcand  = a;
      iMplier = b;
      iValid  = 1'b1;
      sb_q.push_back(16'(a) * 16'(b));
      n = 0;
      while (!oReady && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("ready_timeout", 1, 0);
      tick();
      if (!hold) iValid = 1'b0;
      iMcand  = ~a;
      iMplier = ~b;
      latency = 0;
      while (!oValid && latency < 50) begin
         tick();
         latency++;
         sel_log[latency] = oBoothSel;
      end
      if (latency >= 50) chk("valid_timeout", 1, 0);
      e = sb_q.pop_front();
      n_out++;
      chk("prod", oProd, e);
      if (bp > 0) begin
         iReady = 1'b0;
         for (int i = 0; i < bp; i++) begin
            iValid = i[0];
            tick();
            chk("bp_valid", oValid, 1);
            chk("bp_prod", oProd, e);
            chk("bp_ready", oReady, 0);
         end
         iValid = hold;
         iReady = 1'b1;
      end
      tick();
      chk("valid_drop", oValid, 0);
   endtask

   initial begin
      iRst_n  = 1'b0;
      iValid  = 1'b0;
      iReady  = 1'b1;
      iMcand  = '0;
      iMplier = '0;
      repeat (3) tick();
      iRst_n = 1'b1;
      tick();

      chk("rst_ready", oReady, 1);
      chk("rst_valid", oValid, 0);
      chk("rst_prod", oProd, 0);
      chk("rst_sel", oBoothSel, 0);
      chk("rst_busy", oBusy, 0);

      do_op(8'hFF, 8'hFF, 0, 0, lat);
      chk("lat_ff", lat, 4);
      for (int j = 0; j < 3; j++)
         chk("sel_ff", sel_log[j+1], exp_sel(9'h0FF, j));
      chk("sel_done", sel_log[4], 0);

      do_op(8'h5A, 8'h00, 0, 0, lat);
`ifdef EARLY_TERM_EN
      chk("lat_zero", lat, 2);
`else
      chk("lat_zero", lat, 4);
`endif

      do_op(8'h13, 8'h07, 0, 10, lat);

      iMcand  = 8'h11;
      iMplier = 8'h22;
      iValid  = 1'b1;
      tick();
      iValid = 1'b0;
      tick();
      chk("mid_busy", oBusy, 1);
      #2;
      iRst_n = 1'b0;
      #1;
      chk("arst_valid", oValid, 0);
      chk("arst_busy", oBusy, 0);
      chk("arst_prod", oProd, 0);
      chk("arst_sel", oBoothSel, 0);
      chk("arst_ready", oReady, 1);
      tick();
      iRst_n = 1'b1;
      tick();
      do_op(8'h03, 8'h05, 0, 0, lat);

      n_out = 0;
      for (int i = 0; i < 100; i++) begin
         do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1, 0, lat);
`ifndef EARLY_TERM_EN
         if (lat != 4) chk("lat_rand", lat, 4);
`endif
      end
      iValid = 1'b0;
      chk("rand_count", n_out, 100);
      chk("sb_empty", sb_q.size(), 0);
      repeat (3) tick();
      chk("end_idle", oBusy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
